// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter, its two requesters and the shared memory port.
// master is the arbiter's view; slave is the view of the requesters and memory around it.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic [DATA_W-1:0] i_rdata;

   logic                d_req;
   logic                d_we;
   logic [DATA_W/8-1:0] d_be;
   logic [ADDR_W-1:0]   d_addr;
   logic [DATA_W-1:0]   d_wdata;
   logic                d_gnt;
   logic                d_rvalid;
   logic [DATA_W-1:0]   d_rdata;

   logic                mem_req;
   logic                mem_we;
   logic [DATA_W/8-1:0] mem_be;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic                mem_gnt;
   logic                mem_rvalid;
   logic [DATA_W-1:0]   mem_rdata;

   logic busy;

   modport master (
      input  i_req, i_addr,
      output i_gnt, i_rvalid, i_rdata,
      input  d_req, d_we, d_be, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output busy
   );

   modport slave (
      output i_req, i_addr,
      input  i_gnt, i_rvalid, i_rdata,
      output d_req, d_we, d_be, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port, one outstanding transaction at a time.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate owners on contention; otherwise data always wins.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.master bus
);
   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RSP
   } state_t;

   typedef enum logic {
      OWN_FETCH,
      OWN_DATA
   } owner_t;

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic              mem_req_q, mem_req_d;
   logic              busy_q, busy_d;
   logic              mem_we_q, mem_we_d;
   logic [BE_W-1:0]   mem_be_q, mem_be_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   owner_t            last_owner_q, last_owner_d;
`endif

   logic prefer_data;
   logic pick_data;
   logic gnt_fire;
   logic rsp_fire;
   logic i_rsp;
   logic d_rsp;

   // Contention policy: only consulted when both requesters are pending in IDLE.
`ifdef MEM_ARB_ROUND_ROBIN_EN
   assign prefer_data = (last_owner_q == OWN_FETCH);
`else
   assign prefer_data = 1'b1;
`endif

   assign pick_data = bus.d_req && (!bus.i_req || prefer_data);
   assign gnt_fire  = (state_q == ISSUE) && bus.mem_gnt;
   assign rsp_fire  = (state_q == WAIT_RSP) && bus.mem_rvalid;
   assign i_rsp     = rsp_fire && (owner_q == OWN_FETCH);
   assign d_rsp     = rsp_fire && (owner_q == OWN_DATA);

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      mem_req_d   = mem_req_q;
      busy_d      = busy_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner_d = last_owner_q;
`endif

      case (state_q)
         IDLE: begin
            if (bus.i_req || bus.d_req) begin
               state_d   = ISSUE;
               mem_req_d = 1'b1;
               busy_d    = 1'b1;
               if (pick_data) begin
                  owner_d     = OWN_DATA;
                  mem_we_d    = bus.d_we;
                  mem_be_d    = bus.d_be;
                  mem_addr_d  = bus.d_addr;
                  mem_wdata_d = bus.d_wdata;
               end else begin
                  owner_d     = OWN_FETCH;
                  mem_we_d    = 1'b0;
                  mem_be_d    = '1;
                  mem_addr_d  = bus.i_addr;
                  mem_wdata_d = '0;
               end
`ifdef MEM_ARB_ROUND_ROBIN_EN
               last_owner_d = pick_data ? OWN_DATA : OWN_FETCH;
`endif
            end
         end
         ISSUE: begin
            if (bus.mem_gnt) begin
               state_d   = WAIT_RSP;
               mem_req_d = 1'b0;
            end
         end
         WAIT_RSP: begin
            if (bus.mem_rvalid) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            busy_d    = 1'b0;
         end
      endcase

      // Read data is captured so each port keeps showing its last delivered word.
      if (i_rsp) begin
         i_rdata_d = bus.mem_rdata;
      end
      if (d_rsp) begin
         d_rdata_d = bus.mem_rdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_FETCH;
         mem_req_q   <= 1'b0;
         busy_q      <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_owner_q <= OWN_FETCH;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         mem_req_q   <= mem_req_d;
         busy_q      <= busy_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_owner_q <= last_owner_d;
`endif
      end
   end

   // Accept and response pulses follow the memory handshake in the same cycle.
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;

   assign bus.i_gnt    = gnt_fire && (owner_q == OWN_FETCH);
   assign bus.d_gnt    = gnt_fire && (owner_q == OWN_DATA);
   assign bus.i_rvalid = i_rsp;
   assign bus.d_rvalid = d_rsp;
   assign bus.i_rdata  = i_rsp ? bus.mem_rdata : i_rdata_q;
   assign bus.d_rdata  = d_rsp ? bus.mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: randomized fetch/data traffic and a randomized memory,
// checked against a transaction-level model; honours MEM_ARB_ROUND_ROBIN_EN like the design.
module tb_mem_port_arbiter;

   typedef struct packed {
      bit          owner;
      bit          we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          chk_wd;
   } item_t;

   logic clk;
   logic reset;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   int    tests;
   int    fails;
   item_t exp_cmd[$];
   bit    rsp_pending;
   bit    rsp_owner;
   logic [31:0] exp_i_rdata;
   logic [31:0] exp_d_rdata;

   bit          mem_rand;
   logic        dir_gnt, dir_rvalid;
   logic [31:0] dir_rdata;
   logic        rnd_gnt, rnd_rvalid;
   logic [31:0] rnd_rdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   bit model_last;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory side: either random handshakes or values set by the directed sections.
   always @(posedge clk) begin
      #1;
      rnd_gnt    = ($urandom_range(0, 1) == 1);
      rnd_rvalid = ($urandom_range(0, 2) == 0);
      rnd_rdata  = $urandom;
   end

   assign bus.mem_gnt    = mem_rand ? rnd_gnt    : dir_gnt;
   assign bus.mem_rvalid = mem_rand ? rnd_rvalid : dir_rvalid;
   assign bus.mem_rdata  = mem_rand ? rnd_rdata  : dir_rdata;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic noteOwner(input bit isData);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      model_last = isData;
`else
      if (isData) begin end
`endif
   endtask

   // Monitor: pops the expected command at each memory accept and checks the routed response.
   always @(negedge clk) begin
      item_t head;
      if (reset) begin
         exp_cmd.delete();
         rsp_pending = 1'b0;
         exp_i_rdata = '0;
         exp_d_rdata = '0;
      end else begin
         if (rsp_pending || bus.mem_req) checkOutput("busy_active", bus.busy, 1);
         if (rsp_pending && bus.mem_rvalid) begin
            if (rsp_owner) exp_d_rdata = bus.mem_rdata;
            else           exp_i_rdata = bus.mem_rdata;
            checkOutput("i_rvalid_rsp", bus.i_rvalid, !rsp_owner);
            checkOutput("d_rvalid_rsp", bus.d_rvalid, rsp_owner);
            rsp_pending = 1'b0;
         end else begin
            checkOutput("i_rvalid_quiet", bus.i_rvalid, 0);
            checkOutput("d_rvalid_quiet", bus.d_rvalid, 0);
         end
         checkOutput("i_rdata", bus.i_rdata, exp_i_rdata);
         checkOutput("d_rdata", bus.d_rdata, exp_d_rdata);
         if (bus.mem_req) begin
            if (exp_cmd.size() == 0) begin
               checkOutput("unexpected_mem_req", bus.mem_req, 0);
            end else begin
               head = exp_cmd[0];
               checkOutput("mem_addr", bus.mem_addr, head.addr);
               checkOutput("mem_we", bus.mem_we, head.we);
               checkOutput("mem_be", bus.mem_be, head.be);
               if (head.chk_wd) checkOutput("mem_wdata", bus.mem_wdata, head.wdata);
               checkOutput("i_gnt", bus.i_gnt, bus.mem_gnt && !head.owner);
               checkOutput("d_gnt", bus.d_gnt, bus.mem_gnt && head.owner);
               if (bus.mem_gnt) begin
                  void'(exp_cmd.pop_front());
                  rsp_pending = 1'b1;
                  rsp_owner   = head.owner;
               end
            end
         end else begin
            checkOutput("i_gnt_quiet", bus.i_gnt, 0);
            checkOutput("d_gnt_quiet", bus.d_gnt, 0);
         end
      end
   end

   task automatic waitGnt(input bit isData);
      int  n;
      bit  seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         @(negedge clk);
         n++;
         seen = isData ? bus.d_gnt : bus.i_gnt;
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("[TB] FAIL gnt_timeout: got no gnt for requester %0d, expected gnt within 200 cycles", isData);
      end
      @(posedge clk);
      #1;
      if (isData) bus.d_req = 1'b0;
      else        bus.i_req = 1'b0;
   endtask

   task automatic waitQuiet();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while ((exp_cmd.size() != 0 || rsp_pending || bus.busy) && n < 300);
      if (n >= 300) begin
         tests++;
         fails++;
         $display("[TB] FAIL quiet_timeout: busy=%0d pending=%0d, expected idle", bus.busy, rsp_pending);
      end
   endtask

   // One round: model predicts grant order, then requesters hold until granted.
   task automatic applyStimulus(input bit useF, input bit useD, input logic [31:0] fAddr,
                                input bit we, input logic [3:0] be, input logic [31:0] dAddr,
                                input logic [31:0] wdata);
      item_t fi, di;
      bit    dFirst;
      fi = '{owner: 1'b0, we: 1'b0, be: 4'hF, addr: fAddr, wdata: 32'h0, chk_wd: 1'b0};
      di = '{owner: 1'b1, we: we, be: be, addr: dAddr, wdata: wdata, chk_wd: 1'b1};
      if (useF && useD) begin
         dFirst = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         dFirst = (model_last == 1'b0);
`endif
         if (dFirst) begin
            exp_cmd.push_back(di);
            exp_cmd.push_back(fi);
            noteOwner(1'b0);
         end else begin
            exp_cmd.push_back(fi);
            exp_cmd.push_back(di);
            noteOwner(1'b1);
         end
      end else if (useF) begin
         exp_cmd.push_back(fi);
         noteOwner(1'b0);
      end else begin
         exp_cmd.push_back(di);
         noteOwner(1'b1);
      end
      @(posedge clk);
      #1;
      bus.i_addr  = fAddr;
      bus.d_we    = we;
      bus.d_be    = be;
      bus.d_addr  = dAddr;
      bus.d_wdata = wdata;
      bus.i_req   = useF;
      bus.d_req   = useD;
      fork
         begin if (useF) waitGnt(1'b0); end
         begin if (useD) waitGnt(1'b1); end
      join
      waitQuiet();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      tests = 0;
      fails = 0;
      mem_rand = 1'b0;
      dir_gnt = 1'b0;
      dir_rvalid = 1'b0;
      dir_rdata = '0;
      bus.i_req = 1'b0;
      bus.i_addr = '0;
      bus.d_req = 1'b0;
      bus.d_we = 1'b0;
      bus.d_be = '0;
      bus.d_addr = '0;
      bus.d_wdata = '0;
      reset = 1'b1;
      noteOwner(1'b0);

      // Reset values while reset is held.
      @(negedge clk);
      checkOutput("rst_mem_req", bus.mem_req, 0);
      checkOutput("rst_mem_we", bus.mem_we, 0);
      checkOutput("rst_mem_be", bus.mem_be, 0);
      checkOutput("rst_mem_addr", bus.mem_addr, 0);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_i_rdata", bus.i_rdata, 0);
      checkOutput("rst_d_rdata", bus.d_rdata, 0);
      @(posedge clk);
      #2;
      reset = 1'b0;

      // Minimum latency fetch with memory always ready; then spurious rvalid while idle.
      @(posedge clk);
      #1;
      dir_gnt = 1'b1;
      dir_rvalid = 1'b1;
      dir_rdata = 32'hDEADBEEF;
      exp_cmd.push_back('{owner: 1'b0, we: 1'b0, be: 4'hF, addr: 32'h100, wdata: 32'h0, chk_wd: 1'b0});
      noteOwner(1'b0);
      @(posedge clk);
      #1;
      bus.i_addr = 32'h100;
      bus.i_req = 1'b1;
      @(negedge clk);
      checkOutput("lat_mem_req_N", bus.mem_req, 0);
      @(negedge clk);
      checkOutput("lat_mem_req_N1", bus.mem_req, 1);
      checkOutput("lat_i_gnt_N1", bus.i_gnt, 1);
      @(posedge clk);
      #1;
      bus.i_req = 1'b0;
      @(negedge clk);
      checkOutput("lat_i_rvalid_N2", bus.i_rvalid, 1);
      checkOutput("lat_i_rdata_N2", bus.i_rdata, 32'hDEADBEEF);
      checkOutput("lat_d_rvalid_N2", bus.d_rvalid, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("spur_i_rvalid", bus.i_rvalid, 0);
         checkOutput("spur_d_rvalid", bus.d_rvalid, 0);
         checkOutput("spur_busy", bus.busy, 0);
         checkOutput("hold_i_rdata", bus.i_rdata, 32'hDEADBEEF);
      end

      // Data write held off by the memory for five cycles.
      @(posedge clk);
      #1;
      dir_gnt = 1'b0;
      dir_rvalid = 1'b0;
      exp_cmd.push_back('{owner: 1'b1, we: 1'b1, be: 4'h3, addr: 32'h200, wdata: 32'h12345678, chk_wd: 1'b1});
      noteOwner(1'b1);
      bus.d_we = 1'b1;
      bus.d_be = 4'h3;
      bus.d_addr = 32'h200;
      bus.d_wdata = 32'h12345678;
      bus.d_req = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput("stall_mem_req", bus.mem_req, 1);
         checkOutput("stall_mem_addr", bus.mem_addr, 32'h200);
         checkOutput("stall_d_gnt", bus.d_gnt, 0);
      end
      @(posedge clk);
      #1;
      dir_gnt = 1'b1;
      @(negedge clk);
      checkOutput("wr_d_gnt", bus.d_gnt, 1);
      checkOutput("wr_mem_we", bus.mem_we, 1);
      checkOutput("wr_mem_be", bus.mem_be, 4'h3);
      @(posedge clk);
      #1;
      bus.d_req = 1'b0;
      dir_gnt = 1'b0;
      dir_rvalid = 1'b1;
      dir_rdata = 32'h0000A5A5;
      @(negedge clk);
      checkOutput("wr_d_rvalid", bus.d_rvalid, 1);
      checkOutput("wr_i_rvalid", bus.i_rvalid, 0);
      @(posedge clk);
      #1;
      dir_rvalid = 1'b0;
      waitQuiet();

      // Reset while waiting for the response abandons the transaction.
      @(posedge clk);
      #1;
      dir_gnt = 1'b1;
      exp_cmd.push_back('{owner: 1'b0, we: 1'b0, be: 4'hF, addr: 32'h300, wdata: 32'h0, chk_wd: 1'b0});
      bus.i_addr = 32'h300;
      bus.i_req = 1'b1;
      waitGnt(1'b0);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_busy", bus.busy, 0);
      checkOutput("mid_rst_mem_req", bus.mem_req, 0);
      checkOutput("mid_rst_d_rdata", bus.d_rdata, 0);
      noteOwner(1'b0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      dir_gnt = 1'b0;
      dir_rvalid = 1'b1;
      dir_rdata = 32'hBAD0BAD0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checkOutput("post_rst_i_rvalid", bus.i_rvalid, 0);
         checkOutput("post_rst_d_rvalid", bus.d_rvalid, 0);
         checkOutput("post_rst_busy", bus.busy, 0);
      end
      @(posedge clk);
      #1;
      dir_rvalid = 1'b0;

      // Contention right after reset, then randomized traffic against a random memory.
      mem_rand = 1'b1;
      applyStimulus(1'b1, 1'b1, 32'h400, 1'b0, 4'hF, 32'h500, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h404, 1'b1, 4'hC, 32'h504, 32'hCAFEF00D);
      for (int r = 0; r < 60; r++) begin
         int pat;
         pat = $urandom_range(1, 3);
         applyStimulus(pat[0], pat[1], $urandom, $urandom_range(0, 1) == 1,
                       4'($urandom_range(0, 15)), $urandom, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of requesters and memory port.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byte enables are DATA_W/8 bits.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports i_req/i_addr  input  1/ADDR_W  instruction-fetch read request and address.
REQ-006 SHALL have ports i_gnt/i_rvalid/i_rdata  output  1/1/DATA_W  fetch accept pulse, response pulse, read data.
REQ-007 SHALL have ports d_req/d_we/d_be/d_addr/d_wdata  input  1/1/DATA_W/8/ADDR_W/DATA_W  data-access request.
REQ-008 SHALL have ports d_gnt/d_rvalid/d_rdata  output  1/1/DATA_W  data accept pulse, response pulse, read data.
REQ-009 SHALL have ports mem_req/mem_we/mem_be/mem_addr/mem_wdata  output  1/1/DATA_W/8/ADDR_W/DATA_W  shared memory command.
REQ-010 SHALL have ports mem_gnt/mem_rvalid/mem_rdata  input  1/1/DATA_W  memory accept, response (read data or write ack), read data.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, ISSUE, WAIT_RSP; one outstanding transaction maximum.
REQ-013 IDLE: if any request pending, SHALL select owner, register its command fields, enter ISSUE next cycle; otherwise stay.
REQ-014 ISSUE: mem_req SHALL be 1 with registered fields, stable until mem_gnt=1.
REQ-015 On mem_gnt=1 in ISSUE, owner's x_gnt SHALL pulse that same cycle (combinational from mem_gnt) and state SHALL move to WAIT_RSP.
REQ-016 WAIT_RSP: on mem_rvalid=1, owner's x_rvalid SHALL pulse one cycle with x_rdata=mem_rdata, and state SHALL return to IDLE.
REQ-017 Fetch requests SHALL drive mem_we=0 and mem_be=all ones.
REQ-018 Requesters SHALL hold x_req and fields until x_gnt; arbiter samples fields only in IDLE.
REQ-019 mem_rvalid in IDLE or ISSUE SHALL be ignored; non-owner x_rvalid SHALL stay 0.
REQ-020 Minimum latency: x_req at cycle N, mem_req at N+1, x_gnt at N+1 if mem_gnt=1, x_rvalid at N+2 if mem_rvalid=1.
REQ-021 Back-to-back: IDLE re-entered after response SHALL allow next mem_req one cycle later (one idle cycle between transactions).
REQ-022 x_rdata SHALL hold last delivered value between responses.

Reset
REQ-023 On reset=1, state SHALL be IDLE, mem_req/mem_we/i_gnt/d_gnt/i_rvalid/d_rvalid/busy=0, mem_addr/mem_wdata/mem_be/i_rdata/d_rdata=0, last-owner=fetch, immediately and asynchronously.
REQ-024 Reset mid-transaction SHALL abandon it; no gnt or rvalid SHALL be emitted for it after release.

Configuration
REQ-025 Macro MEM_ARB_ROUND_ROBIN_EN defined: when both request in IDLE, grant SHALL go to the requester not granted last; single request always granted.
REQ-026 Macro undefined: when both request, data SHALL always win; last-owner register SHALL be omitted.

Verification
REQ-027 Fetch only, i_addr=0x100, mem_gnt/mem_rvalid tied 1, mem_rdata=0xDEADBEEF -> mem_req at N+1, i_gnt at N+1, i_rvalid=1 and i_rdata=0xDEADBEEF at N+2.
REQ-028 Data write d_addr=0x200, d_wdata=0x12345678, d_be=0x3 -> mem_we=1, mem_be=0x3, d_gnt, then d_rvalid on write ack; i_rvalid stays 0.
REQ-029 Both requesting continuously, 4 transactions -> with MEM_ARB_ROUND_ROBIN_EN owners D,F,D,F (last-owner fetch after reset); without it D,D,D,D.
REQ-030 mem_gnt held 0 for 5 cycles -> mem_req and mem_addr stable for all 5, x_gnt only on the cycle mem_gnt rises.
REQ-031 Reset asserted in WAIT_RSP, then mem_rvalid=1 after release -> no x_rvalid, busy=0, next request serviced normally.
REQ-032 Spurious mem_rvalid=1 in IDLE -> i_rvalid=d_rvalid=0, state unchanged.
